core_bus_arbiter: RTL and testbench
===================================

// Module: core_bus_arbiter
// PURPOSE
//   Shares one cbus memory port between the core's instruction bus and data bus.
//   Sits between core (ireq/iresp, dreq/dresp) and the memory/cache side (oreq/oresp).
//   Issues one single-beat cbus transaction at a time; dbus has priority, with a
//   starvation guard for ibus. Replaces ad-hoc bus merging at the SoC top.
// PARAMETERS
//   STARVE_LIMIT  4  consecutive dbus grants taken while ibus waits; the next contended pick goes to ibus
// PORTS
//   clk    in   1              clock
//   reset  in   1              synchronous, active-high reset
//   ireq   in   ibus_req_t     fetch request (valid, addr)
//   iresp  out  ibus_resp_t    fetch response (addr_ok, data_ok, data)
//   dreq   in   dbus_req_t     data request (valid, addr, size, strobe, data)
//   dresp  out  dbus_resp_t    data response (addr_ok, data_ok, data)
//   oreq   out  cbus_req_t     merged request (valid, is_write, size, addr, strobe, data, len, burst)
//   oresp  in   cbus_resp_t    merged response (ready, last, data)
// BEHAVIOUR
//   - One clock (clk); reset is synchronous and active-high.
//   - On reset:
//       state=IDLE, owner=NONE, starve_cnt=0, latched request cleared.
//       All outputs are 0 from the next edge: oreq.valid, iresp.*, dresp.*.
//   - IDLE:
//       owner selection if dreq.valid & ireq.valid:
//         owner=I if starve_cnt==STARVE_LIMIT, else owner=D.
//       owner selection if only one valid: that one.
//       latching: the selected request is latched into req_q; go to BUSY.
//       oreq.valid stays 0 in IDLE (registered issue).
//   - BUSY:
//       oreq is driven from req_q with valid=1.
//       oreq fields for owner D:
//         is_write=|strobe, size=dreq.size, addr, strobe and data as latched.
//       oreq fields for owner I:
//         is_write=0, size=MSIZE4, strobe=0, data=0.
//       always: len=MLEN1, burst=AXI_BURST_FIXED.
//       oreq is held stable until oresp.ready & oresp.last.
//       on oresp.ready & oresp.last, in that same cycle (combinational):
//         the owner's addr_ok=data_ok=1 and data=oresp.data.
//         the other requester sees 0.
//       next state: IDLE.
//   - Latency: request accepted in cycle N (IDLE) -> oreq.valid in N+1 -> response
//     in the cycle memory asserts ready&last (minimum N+1). Returning to IDLE gives
//     one bubble cycle between back-to-back transactions.
//   - Requester holds valid and its fields until data_ok (codebase bus rule).
//     If the owner drops valid while BUSY, the transaction still completes on cbus
//     and the response is discarded (no addr_ok/data_ok pulse).
//   - starve_cnt:
//       on a D grant while ireq.valid: starve_cnt += 1, saturating at STARVE_LIMIT.
//       on a D grant with ireq idle: no change.
//       on any I grant: starve_cnt = 0.
//   - oresp.ready in IDLE is ignored; no response is ever forwarded in IDLE.
//   - Reset asserted mid-BUSY:
//       the transaction is abandoned, oreq.valid=0 from the next edge.
//       no response is delivered.
// STRUCTURE
//   - Package common:
//       typedef enum {ARB_IDLE, ARB_BUSY} arb_state_t
//       typedef enum {OWN_NONE, OWN_I, OWN_D} arb_owner_t
//   - Single module; the pick logic stays an always_comb block, no sub-module needed.
//   - State, owner, req_q and starve_cnt are all updated in one always_ff on clk.
// TESTING
//   1. Data only:
//      dreq{valid, addr=0x8000_0100, size=MSIZE8, strobe=0xFF, data=0x1122}, mem ready&last after 3 cycles
//      -> oreq is_write=1, addr=0x8000_0100, held 3 cycles
//      -> dresp.data_ok=1 for exactly 1 cycle; iresp stays 0.
//   2. Contention, STARVE_LIMIT=4:
//      ireq and dreq both valid continuously, dreq re-raised after each response
//      -> grant order D,D,D,D,I,D...; starve_cnt=0 after the I grant.
//   3. Instruction fetch: ireq{addr=0x8000_0000}, oresp.data=0x0000_0013_0000_0093
//      -> oreq is_write=0, size=MSIZE4, strobe=0 -> iresp.data equals oresp.data with data_ok.
//   4. Owner drops valid mid-BUSY: dreq.valid deasserted 1 cycle after grant
//      -> oreq held until ready&last, no dresp pulse, then IDLE.
//   5. Reset mid-BUSY: reset high while oreq.valid=1
//      -> next cycle oreq.valid=0, no responses, starve_cnt=0; a fresh ireq after reset is served normally.
//   6. Back-to-back: a second dreq raised in the completion cycle
//      -> one IDLE bubble, then oreq.valid at completion+2.

Source files
------------

// File: rtl/core_bus_arbiter_pkg.sv
// Shared bus types for the core-to-cbus arbiter.
// Request/response bundles, arbiter state and owner encodings.
package core_bus_arbiter_pkg;

    typedef logic [63:0] addr_t;
    typedef logic [63:0] word_t;
    typedef logic [7:0]  strobe_t;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef enum logic [3:0] {
        MLEN1 = 4'd0,
        MLEN2 = 4'd1,
        MLEN4 = 4'd3,
        MLEN8 = 4'd7
    } mlen_t;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'd0,
        AXI_BURST_INCR  = 2'd1,
        AXI_BURST_WRAP  = 2'd2
    } axi_burst_t;

    typedef struct packed {
        logic  valid;
        addr_t addr;
    } ibus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } ibus_resp_t;

    typedef struct packed {
        logic    valid;
        addr_t   addr;
        msize_t  size;
        strobe_t strobe;
        word_t   data;
    } dbus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } dbus_resp_t;

    typedef struct packed {
        logic       valid;
        logic       is_write;
        msize_t     size;
        addr_t      addr;
        strobe_t    strobe;
        word_t      data;
        mlen_t      len;
        axi_burst_t burst;
    } cbus_req_t;

    typedef struct packed {
        logic  ready;
        logic  last;
        word_t data;
    } cbus_resp_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } arb_owner_t;

    function automatic cbus_req_t i_to_cbus(addr_t addr);
        cbus_req_t c;
        c          = '0;
        c.valid    = 1'b1;
        c.is_write = 1'b0;
        c.size     = MSIZE4;
        c.addr     = addr;
        c.len      = MLEN1;
        c.burst    = AXI_BURST_FIXED;
        return c;
    endfunction

    function automatic cbus_req_t d_to_cbus(dbus_req_t d);
        cbus_req_t c;
        c          = '0;
        c.valid    = 1'b1;
        c.is_write = |d.strobe;
        c.size     = d.size;
        c.addr     = d.addr;
        c.strobe   = d.strobe;
        c.data     = d.data;
        c.len      = MLEN1;
        c.burst    = AXI_BURST_FIXED;
        return c;
    endfunction

endpackage

// File: rtl/core_bus_arbiter_if.sv
// Bundle of the core-side ibus/dbus and the merged cbus port.
// slave is the arbiter view, master is the core+memory view.
interface core_bus_arbiter_if;
    import core_bus_arbiter_pkg::*;

    ibus_req_t  ireq;
    ibus_resp_t iresp;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    cbus_req_t  oreq;
    cbus_resp_t oresp;

    modport slave (
        input  ireq,
        input  dreq,
        input  oresp,
        output iresp,
        output dresp,
        output oreq
    );

    modport master (
        output ireq,
        output dreq,
        output oresp,
        input  iresp,
        input  dresp,
        input  oreq
    );

endinterface

// File: rtl/core_bus_arbiter.sv
// Merges ibus and dbus onto one single-beat cbus port.
// dbus wins contention until ibus has waited STARVE_LIMIT grants.
module core_bus_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               reset,
    core_bus_arbiter_if.slave bus
);
    import core_bus_arbiter_pkg::*;

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    arb_state_t    state;
    arb_owner_t    owner;
    arb_owner_t    pick;
    cbus_req_t     req_q;
    logic [CW-1:0] starve_cnt;
    logic          dropped_q;
    logic          done;
    logic          owner_valid;
    logic          deliver;

    always_comb begin
        pick = OWN_NONE;
        unique case (1'b1)
            bus.dreq.valid && bus.ireq.valid:
                pick = (starve_cnt == LIMIT) ? OWN_I : OWN_D;
            bus.dreq.valid && !bus.ireq.valid:
                pick = OWN_D;
            !bus.dreq.valid && bus.ireq.valid:
                pick = OWN_I;
            default: pick = OWN_NONE;
        endcase
    end

    always_comb begin
        owner_valid = 1'b0;
        unique case (owner)
            OWN_I:   owner_valid = bus.ireq.valid;
            OWN_D:   owner_valid = bus.dreq.valid;
            default: owner_valid = 1'b0;
        endcase
    end

    assign done = (state == ARB_BUSY) && !reset
                  && bus.oresp.ready && bus.oresp.last;
    // A requester that let go of valid mid-flight no longer wants the answer.
    assign deliver = done && owner_valid && !dropped_q;

    always_comb begin
        bus.oreq  = (state == ARB_BUSY) ? req_q : '0;
        bus.iresp = '0;
        bus.dresp = '0;
        if (deliver && owner == OWN_I) begin
            bus.iresp.addr_ok = 1'b1;
            bus.iresp.data_ok = 1'b1;
            bus.iresp.data    = bus.oresp.data;
        end
        if (deliver && owner == OWN_D) begin
            bus.dresp.addr_ok = 1'b1;
            bus.dresp.data_ok = 1'b1;
            bus.dresp.data    = bus.oresp.data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB_IDLE;
            owner      <= OWN_NONE;
            req_q      <= '0;
            starve_cnt <= '0;
            dropped_q  <= 1'b0;
        end else begin
            unique case (state)
                ARB_IDLE: begin
                    if (pick != OWN_NONE) begin
                        state     <= ARB_BUSY;
                        owner     <= pick;
                        dropped_q <= 1'b0;
                    end
                    if (pick == OWN_D) begin
                        req_q <= d_to_cbus(bus.dreq);
                        if (bus.ireq.valid && starve_cnt != LIMIT)
                            starve_cnt <= starve_cnt + 1'b1;
                    end
                    if (pick == OWN_I) begin
                        req_q      <= i_to_cbus(bus.ireq.addr);
                        starve_cnt <= '0;
                    end
                end
                ARB_BUSY: begin
                    if (!owner_valid)
                        dropped_q <= 1'b1;
                    if (bus.oresp.ready && bus.oresp.last) begin
                        state <= ARB_IDLE;
                        owner <= OWN_NONE;
                        req_q <= '0;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Self-checking bench for core_bus_arbiter.
// Scenario tasks plus randomized traffic against a grant-rule model.
module tb_core_bus_arbiter;
    import core_bus_arbiter_pkg::*;

    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   mcnt = 0;

    always #5 clk = ~clk;

    core_bus_arbiter_if bus();

    core_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.ireq  = '0;
        bus.dreq  = '0;
        bus.oresp = '0;
    endtask

    // Grant rule: count ibus waits behind dbus, hand over at the limit.
    function automatic arb_owner_t model_grant(bit iv, bit dv);
        arb_owner_t o;
        if (!iv && !dv) return OWN_NONE;
        if (iv && dv) o = (mcnt >= LIMIT) ? OWN_I : OWN_D;
        else o = dv ? OWN_D : OWN_I;
        if (o == OWN_I) mcnt = 0;
        else if (iv) mcnt = (mcnt + 1 > LIMIT) ? LIMIT : mcnt + 1;
        return o;
    endfunction

    function automatic cbus_req_t exp_req(arb_owner_t o,
                                          ibus_req_t i,
                                          dbus_req_t d);
        cbus_req_t c;
        c = '0;
        if (o == OWN_D)
            c = '{valid: 1'b1, is_write: (d.strobe != 8'h00),
                  size: d.size, addr: d.addr, strobe: d.strobe,
                  data: d.data, len: MLEN1,
                  burst: AXI_BURST_FIXED};
        if (o == OWN_I)
            c = '{valid: 1'b1, is_write: 1'b0, size: MSIZE4,
                  addr: i.addr, strobe: 8'h00, data: 64'h0,
                  len: MLEN1, burst: AXI_BURST_FIXED};
        return c;
    endfunction

    function automatic ibus_req_t rand_i();
        ibus_req_t r;
        r.valid = 1'b1;
        r.addr  = 64'h8000_0000 + 64'($urandom_range(0, 1023)) * 4;
        return r;
    endfunction

    function automatic dbus_req_t rand_d();
        dbus_req_t r;
        r.valid  = 1'b1;
        r.addr   = 64'h9000_0000 + 64'($urandom_range(0, 1023)) * 8;
        r.size   = msize_t'($urandom_range(0, 3));
        r.strobe = 8'($urandom);
        if ($urandom_range(0, 3) == 0) r.strobe = 8'h00;
        r.data   = {$urandom, $urandom};
        return r;
    endfunction

    function automatic arb_owner_t obs_owner(cbus_req_t q);
        if (!q.valid) return OWN_NONE;
        return (q.addr[31:28] == 4'h9) ? OWN_D : OWN_I;
    endfunction

    function automatic ibus_resp_t exp_ir(arb_owner_t o, word_t w);
        ibus_resp_t r;
        r = '0;
        if (o == OWN_I) r = '{addr_ok: 1'b1, data_ok: 1'b1, data: w};
        return r;
    endfunction

    function automatic dbus_resp_t exp_dr(arb_owner_t o, word_t w);
        dbus_resp_t r;
        r = '0;
        if (o == OWN_D) r = '{addr_ok: 1'b1, data_ok: 1'b1, data: w};
        return r;
    endfunction

    // Memory side: wait for a request, hold it lat cycles, then answer.
    task automatic mem_serve(input int lat, input word_t rdata,
                             output cbus_req_t q, output bit stable,
                             output bit early, output ibus_resp_t ir,
                             output dbus_resp_t dr);
        bit got;
        got = 1'b0; stable = 1'b1; early = 1'b0;
        q = '0; ir = '0; dr = '0;
        for (int n = 0; n < 20; n++) begin
            if (bus.oreq.valid) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        if (!got) return;
        q = bus.oreq;
        for (int c = 1; c < lat; c++) begin
            if (bus.iresp !== '0 || bus.dresp !== '0) early = 1'b1;
            tick();
            if (bus.oreq !== q) stable = 1'b0;
        end
        bus.oresp = '{ready: 1'b1, last: 1'b1, data: rdata};
        #1;
        ir = bus.iresp;
        dr = bus.dresp;
        tick();
        bus.oresp = '0;
    endtask

    task automatic run_txn(input ibus_req_t i, input dbus_req_t d,
                           input int lat, input word_t rdata,
                           output bit idle_v, output cbus_req_t q,
                           output bit stable, output bit early,
                           output ibus_resp_t ir, output dbus_resp_t dr);
        bus.ireq = i;
        bus.dreq = d;
        #1;
        idle_v = bus.oreq.valid;
        mem_serve(lat, rdata, q, stable, early, ir, dr);
    endtask

    task automatic test_reset();
        idle_bus();
        reset = 1'b1;
        bus.ireq = rand_i();
        bus.dreq = rand_d();
        bus.oresp = '{ready: 1'b1, last: 1'b1, data: 64'hdead};
        tick();
        tick();
        total_cnt++;
        if (bus.oreq.valid !== 1'b0)
            $display("FAIL reset_oreq: got %b want 0", bus.oreq.valid);
        else pass_cnt++;
        total_cnt++;
        if (bus.iresp !== '0)
            $display("FAIL reset_iresp: got %h want 0", bus.iresp);
        else pass_cnt++;
        total_cnt++;
        if (bus.dresp !== '0)
            $display("FAIL reset_dresp: got %h want 0", bus.dresp);
        else pass_cnt++;
        idle_bus();
        reset = 1'b0;
        mcnt = 0;
        tick();
    endtask

    task automatic test_data_only();
        dbus_req_t d;
        cbus_req_t q;
        ibus_resp_t ir;
        dbus_resp_t dr;
        bit iv, st, ea;
        d = '{valid: 1'b1, addr: 64'h8000_0100, size: MSIZE8,
              strobe: 8'hff, data: 64'h1122};
        void'(model_grant(1'b0, 1'b1));
        run_txn('0, d, 3, 64'h55aa, iv, q, st, ea, ir, dr);
        total_cnt++;
        if (iv !== 1'b0) $display("FAIL data_idle_valid: got %b want 0", iv);
        else pass_cnt++;
        total_cnt++;
        if (q !== exp_req(OWN_D, '0, d))
            $display("FAIL data_oreq: got %h want %h", q, exp_req(OWN_D, '0, d));
        else pass_cnt++;
        total_cnt++;
        if (st !== 1'b1 || ea !== 1'b0)
            $display("FAIL data_hold: got stable=%b early=%b want 1 0", st, ea);
        else pass_cnt++;
        total_cnt++;
        if (dr !== exp_dr(OWN_D, 64'h55aa))
            $display("FAIL data_dresp: got %h want %h", dr, exp_dr(OWN_D, 64'h55aa));
        else pass_cnt++;
        total_cnt++;
        if (ir !== '0) $display("FAIL data_iresp: got %h want 0", ir);
        else pass_cnt++;
        bus.dreq = '0;
        #1;
        total_cnt++;
        if (bus.dresp.data_ok !== 1'b0 || bus.oreq.valid !== 1'b0)
            $display("FAIL data_after: got ok=%b v=%b want 0 0",
                     bus.dresp.data_ok, bus.oreq.valid);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_contention();
        arb_owner_t order [6] = '{OWN_D, OWN_D, OWN_D, OWN_D, OWN_I, OWN_D};
        arb_owner_t eo;
        ibus_req_t i;
        dbus_req_t d;
        cbus_req_t q;
        ibus_resp_t ir;
        dbus_resp_t dr;
        bit iv, st, ea;
        for (int k = 0; k < 6; k++) begin
            i = rand_i();
            d = rand_d();
            eo = model_grant(1'b1, 1'b1);
            run_txn(i, d, 2, {$urandom, $urandom}, iv, q, st, ea, ir, dr);
            total_cnt++;
            if (obs_owner(q) !== order[k])
                $display("FAIL contention_order[%0d]: got %0d want %0d",
                         k, obs_owner(q), order[k]);
            else pass_cnt++;
            total_cnt++;
            if (q !== exp_req(eo, i, d))
                $display("FAIL contention_oreq[%0d]: got %h want %h",
                         k, q, exp_req(eo, i, d));
            else pass_cnt++;
        end
        idle_bus();
        tick();
    endtask

    task automatic test_fetch();
        ibus_req_t i;
        cbus_req_t q;
        ibus_resp_t ir;
        dbus_resp_t dr;
        bit iv, st, ea;
        word_t w;
        w = 64'h0000_0013_0000_0093;
        i = '{valid: 1'b1, addr: 64'h8000_0000};
        void'(model_grant(1'b1, 1'b0));
        run_txn(i, '0, 2, w, iv, q, st, ea, ir, dr);
        total_cnt++;
        if (q.is_write !== 1'b0 || q.size !== MSIZE4 || q.strobe !== 8'h00)
            $display("FAIL fetch_fields: got w=%b s=%0d st=%h want 0 2 00",
                     q.is_write, q.size, q.strobe);
        else pass_cnt++;
        total_cnt++;
        if (q !== exp_req(OWN_I, i, '0))
            $display("FAIL fetch_oreq: got %h want %h", q, exp_req(OWN_I, i, '0));
        else pass_cnt++;
        total_cnt++;
        if (ir !== exp_ir(OWN_I, w))
            $display("FAIL fetch_iresp: got %h want %h", ir, exp_ir(OWN_I, w));
        else pass_cnt++;
        total_cnt++;
        if (dr !== '0) $display("FAIL fetch_dresp: got %h want 0", dr);
        else pass_cnt++;
        idle_bus();
        tick();
    endtask

    task automatic test_idle_ready();
        cbus_req_t q;
        ibus_resp_t ir;
        dbus_resp_t dr;
        bit st, ea;
        word_t w;
        w = {$urandom, $urandom};
        bus.ireq = rand_i();
        bus.oresp = '{ready: 1'b1, last: 1'b1, data: 64'hbad};
        #1;
        total_cnt++;
        if (bus.iresp !== '0 || bus.dresp !== '0)
            $display("FAIL idle_ready_resp: got %h %h want 0 0",
                     bus.iresp, bus.dresp);
        else pass_cnt++;
        bus.oresp = '0;
        void'(model_grant(1'b1, 1'b0));
        mem_serve(1, w, q, st, ea, ir, dr);
        total_cnt++;
        if (ir !== exp_ir(OWN_I, w))
            $display("FAIL idle_ready_iresp: got %h want %h", ir, exp_ir(OWN_I, w));
        else pass_cnt++;
        idle_bus();
        tick();
    endtask

    task automatic test_drop();
        cbus_req_t q;
        cbus_req_t eq;
        ibus_resp_t ir;
        dbus_resp_t dr;
        bit st, ea;
        bus.dreq = rand_d();
        eq = exp_req(OWN_D, '0, bus.dreq);
        void'(model_grant(1'b0, 1'b1));
        tick();
        bus.dreq.valid = 1'b0;
        mem_serve(3, 64'h77, q, st, ea, ir, dr);
        total_cnt++;
        if (q !== eq || st !== 1'b1)
            $display("FAIL drop_hold: got %h stable=%b want %h 1", q, st, eq);
        else pass_cnt++;
        total_cnt++;
        if (dr !== '0 || ir !== '0 || ea !== 1'b0)
            $display("FAIL drop_resp: got %h %h want 0 0", dr, ir);
        else pass_cnt++;
        total_cnt++;
        if (bus.oreq.valid !== 1'b0)
            $display("FAIL drop_idle: got %b want 0", bus.oreq.valid);
        else pass_cnt++;
        idle_bus();
        tick();
    endtask

    task automatic test_back_to_back();
        dbus_req_t a;
        dbus_req_t b;
        cbus_req_t q;
        ibus_resp_t ir;
        dbus_resp_t dr;
        bit iv, st, ea;
        word_t w;
        a = rand_d();
        b = rand_d();
        w = {$urandom, $urandom};
        void'(model_grant(1'b0, 1'b1));
        run_txn('0, a, 2, 64'h1, iv, q, st, ea, ir, dr);
        bus.dreq = b;
        void'(model_grant(1'b0, 1'b1));
        #1;
        total_cnt++;
        if (bus.oreq.valid !== 1'b0)
            $display("FAIL b2b_bubble: got %b want 0", bus.oreq.valid);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.oreq !== exp_req(OWN_D, '0, b))
            $display("FAIL b2b_issue: got %h want %h",
                     bus.oreq, exp_req(OWN_D, '0, b));
        else pass_cnt++;
        mem_serve(1, w, q, st, ea, ir, dr);
        total_cnt++;
        if (dr !== exp_dr(OWN_D, w))
            $display("FAIL b2b_dresp: got %h want %h", dr, exp_dr(OWN_D, w));
        else pass_cnt++;
        idle_bus();
        tick();
    endtask

    task automatic test_reset_mid_busy();
        arb_owner_t order [5] = '{OWN_D, OWN_D, OWN_D, OWN_D, OWN_I};
        arb_owner_t eo;
        ibus_req_t i;
        cbus_req_t q;
        ibus_resp_t ir;
        dbus_resp_t dr;
        bit iv, st, ea;
        word_t w;
        bus.ireq = rand_i();
        bus.dreq = rand_d();
        void'(model_grant(1'b1, 1'b1));
        tick();
        total_cnt++;
        if (bus.oreq.valid !== 1'b1)
            $display("FAIL rst_busy_pre: got %b want 1", bus.oreq.valid);
        else pass_cnt++;
        reset = 1'b1;
        tick();
        mcnt = 0;
        total_cnt++;
        if (bus.oreq.valid !== 1'b0)
            $display("FAIL rst_busy_oreq: got %b want 0", bus.oreq.valid);
        else pass_cnt++;
        bus.oresp = '{ready: 1'b1, last: 1'b1, data: 64'hbeef};
        #1;
        total_cnt++;
        if (bus.iresp !== '0 || bus.dresp !== '0)
            $display("FAIL rst_busy_resp: got %h %h want 0 0",
                     bus.iresp, bus.dresp);
        else pass_cnt++;
        reset = 1'b0;
        bus.oresp = '0;
        for (int k = 0; k < 5; k++) begin
            eo = model_grant(1'b1, 1'b1);
            w = {$urandom, $urandom};
            run_txn(rand_i(), rand_d(), 1, w, iv, q, st, ea, ir, dr);
            total_cnt++;
            if (obs_owner(q) !== order[k] || obs_owner(q) !== eo)
                $display("FAIL rst_busy_order[%0d]: got %0d want %0d",
                         k, obs_owner(q), order[k]);
            else pass_cnt++;
        end
        i = rand_i();
        w = {$urandom, $urandom};
        void'(model_grant(1'b1, 1'b0));
        run_txn(i, '0, 2, w, iv, q, st, ea, ir, dr);
        total_cnt++;
        if (ir !== exp_ir(OWN_I, w) || q !== exp_req(OWN_I, i, '0))
            $display("FAIL rst_busy_fetch: got %h %h want %h",
                     ir, q, exp_ir(OWN_I, w));
        else pass_cnt++;
        idle_bus();
        tick();
    endtask

    task automatic test_random();
        arb_owner_t eo;
        ibus_req_t i;
        dbus_req_t d;
        cbus_req_t q;
        ibus_resp_t ir;
        dbus_resp_t dr;
        bit iv, st, ea;
        bit ivb, dvb;
        int sel;
        word_t w;
        for (int k = 0; k < 150; k++) begin
            sel = $urandom_range(0, 3);
            ivb = (sel != 1);
            dvb = (sel != 0);
            i = ivb ? rand_i() : '0;
            d = dvb ? rand_d() : '0;
            w = {$urandom, $urandom};
            eo = model_grant(ivb, dvb);
            run_txn(i, d, $urandom_range(1, 4), w, iv, q, st, ea, ir, dr);
            total_cnt++;
            if (q !== exp_req(eo, i, d) || iv !== 1'b0)
                $display("FAIL rand_oreq[%0d]: got %h want %h",
                         k, q, exp_req(eo, i, d));
            else pass_cnt++;
            total_cnt++;
            if (st !== 1'b1 || ea !== 1'b0)
                $display("FAIL rand_hold[%0d]: got %b%b want 10", k, st, ea);
            else pass_cnt++;
            total_cnt++;
            if (ir !== exp_ir(eo, w) || dr !== exp_dr(eo, w))
                $display("FAIL rand_resp[%0d]: got %h %h want %h %h",
                         k, ir, dr, exp_ir(eo, w), exp_dr(eo, w));
            else pass_cnt++;
        end
        idle_bus();
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_bus();
        test_reset();
        test_contention();
        test_data_only();
        test_fetch();
        test_idle_ready();
        test_drop();
        test_back_to_back();
        test_reset_mid_busy();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
